// File: rtl/vga_2048_pkg.sv
// Shared timing, board geometry and colour definitions for the 2048 VGA demo.
package vga_2048_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam int BOARD_X0   = 100;
  localparam int BOARD_X1   = 539;
  localparam int BOARD_Y0   = 20;
  localparam int BOARD_Y1   = 459;
  localparam int TILE_X0    = 108;
  localparam int TILE_Y0    = 28;
  localparam int TILE_SIZE  = 100;
  localparam int TILE_PITCH = 108;
  localparam int TILES      = 4;

  typedef logic [11:0] rgb12_t;
  typedef logic [3:0]  exp_t;

  localparam rgb12_t COL_BG    = 12'hFFE;
  localparam rgb12_t COL_GAP   = 12'hBAA;
  localparam rgb12_t COL_BLACK = 12'h000;

  function automatic rgb12_t exp_colour(input exp_t e);
    case (e)
      4'd0:    return 12'hCBA;
      4'd1:    return 12'hEED;
      4'd2:    return 12'hEEC;
      4'd3:    return 12'hFB7;
      4'd4:    return 12'hF96;
      4'd5:    return 12'hF75;
      4'd6:    return 12'hF53;
      4'd7:    return 12'hEC7;
      4'd8:    return 12'hEC6;
      4'd9:    return 12'hEC5;
      4'd10:   return 12'hEC3;
      4'd11:   return 12'hEC2;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 Hz counters advanced on pix_en; hs/vs/visible registered one tick behind.
module vga_timing
  import vga_2048_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs,
  output logic       vs,
  output logic       visible
);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       visible_q, visible_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap    = (h_cnt_q == 10'(H_TOTAL - 1));
    v_wrap    = (v_cnt_q == 10'(V_TOTAL - 1));
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    visible_d = visible_q;
    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      hs_d      = !((h_cnt_q >= 10'(HS_START)) && (h_cnt_q <= 10'(HS_END)));
      vs_d      = !((v_cnt_q >= 10'(VS_START)) && (v_cnt_q <= 10'(VS_END)));
      visible_d = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      visible_q <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      visible_q <= visible_d;
    end
  end

  assign h_cnt   = h_cnt_q;
  assign v_cnt   = v_cnt_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign visible = visible_q;

endmodule

// File: rtl/vga_demo_top.sv
// 2048 VGA demo top: clock divider, 4x4 exponent board and tile colour mux.
// Define DEMO_ANIM_EN to step every exponent once per 64 frames.
module vga_demo_top
  import vga_2048_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        rst,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic [31:0] clkdiv
);

  logic [31:0] clkdiv_q, clkdiv_d;
  logic        pix_en;
  logic [9:0]  h_cnt, v_cnt;
  logic        visible;
  exp_t        exp_q [16];
  exp_t        exp_d [16];
  rgb12_t      rgb_q, rgb_d, pix_colour;
  logic        in_board, col_hit, row_hit;
  logic [1:0]  col_idx, row_idx;
`ifdef DEMO_ANIM_EN
  logic [5:0]  frame_q, frame_d;
  logic        frame_end;
`endif

  always_comb begin
    clkdiv_d = clkdiv_q + 32'd1;
    pix_en   = (clkdiv_q[1:0] == 2'b11);
  end

  vga_timing u_timing (
    .clk     (clk),
    .clrn    (clrn),
    .pix_en  (pix_en),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .hs      (hs),
    .vs      (vs),
    .visible (visible)
  );

  // Tile decode: a pixel lies in at most one column band and one row band.
  always_comb begin
    in_board = (h_cnt >= 10'(BOARD_X0)) && (h_cnt <= 10'(BOARD_X1)) &&
               (v_cnt >= 10'(BOARD_Y0)) && (v_cnt <= 10'(BOARD_Y1));
    col_hit = 1'b0;
    col_idx = '0;
    row_hit = 1'b0;
    row_idx = '0;
    for (int i = 0; i < TILES; i++) begin
      if ((h_cnt >= 10'(TILE_X0 + TILE_PITCH * i)) &&
          (h_cnt <= 10'(TILE_X0 + TILE_PITCH * i + TILE_SIZE - 1))) begin
        col_hit = 1'b1;
        col_idx = 2'(i);
      end
      if ((v_cnt >= 10'(TILE_Y0 + TILE_PITCH * i)) &&
          (v_cnt <= 10'(TILE_Y0 + TILE_PITCH * i + TILE_SIZE - 1))) begin
        row_hit = 1'b1;
        row_idx = 2'(i);
      end
    end
    if (!in_board)            pix_colour = COL_BG;
    else if (col_hit && row_hit) pix_colour = exp_colour(exp_q[{row_idx, col_idx}]);
    else                      pix_colour = COL_GAP;
    rgb_d = pix_en ? pix_colour : rgb_q;
  end

`ifdef DEMO_ANIM_EN
  assign frame_end = pix_en && (h_cnt == 10'(H_TOTAL - 1)) && (v_cnt == 10'(V_TOTAL - 1));
`endif

  always_comb begin
    exp_d = exp_q;
`ifdef DEMO_ANIM_EN
    frame_d = frame_q;
`endif
    if (rst) begin
      for (int i = 0; i < 16; i++) exp_d[i] = '0;
`ifdef DEMO_ANIM_EN
      frame_d = '0;
    end else if (frame_end) begin
      frame_d = frame_q + 6'd1;
      if (frame_q == 6'd63) begin
        for (int i = 0; i < 16; i++) exp_d[i] = (exp_q[i] >= 4'd11) ? 4'd0 : exp_q[i] + 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clkdiv_q <= '0;
      rgb_q    <= COL_BLACK;
      for (int i = 0; i < 16; i++) exp_q[i] <= exp_t'(i % 12);
`ifdef DEMO_ANIM_EN
      frame_q  <= '0;
`endif
    end else begin
      clkdiv_q <= clkdiv_d;
      rgb_q    <= rgb_d;
      exp_q    <= exp_d;
`ifdef DEMO_ANIM_EN
      frame_q  <= frame_d;
`endif
    end
  end

  // Blanking is applied from the registered visible flag so rgb stays aligned with it.
  assign {r, g, b} = visible ? rgb_q : COL_BLACK;
  assign clkdiv    = clkdiv_q;

endmodule

// File: tb/tb_vga_demo_top.sv
// Bench for vga_demo_top: pixel-position reference model, random line jumps and board clears.
module tb_vga_demo_top;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        rst = 1'b0;
  logic        hs, vs;
  logic [3:0]  r, g, b;
  logic [31:0] clkdiv;
  logic [9:0]  force_v;

  int checks = 0;
  int failures = 0;

  vga_demo_top dut (
    .clk    (clk),
    .clrn   (clrn),
    .rst    (rst),
    .hs     (hs),
    .vs     (vs),
    .r      (r),
    .g      (g),
    .b      (b),
    .clkdiv (clkdiv)
  );

  always #5 clk = ~clk;

  logic [11:0] lut [12] = '{12'hCBA, 12'hEED, 12'hEEC, 12'hFB7, 12'hF96, 12'hF75,
                            12'hF53, 12'hEC7, 12'hEC6, 12'hEC5, 12'hEC3, 12'hEC2};

  // Model: edges since release, pixel position (line*800+x), board, expected outputs.
  int unsigned m_edges = 0;
  int          m_pos = 0;
  logic        m_hs = 1'b1;
  logic        m_vs = 1'b1;
  logic [11:0] m_rgb = 12'h000;
  int          m_board [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_colour(input int x, input int y);
    int xo, yo, e;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x < 100 || x > 539 || y < 20 || y > 459) return 12'hFFE;
    xo = x - 108;
    yo = y - 28;
    if (xo >= 0 && yo >= 0 && (xo % 108) < 100 && (yo % 108) < 100 &&
        (xo / 108) < 4 && (yo / 108) < 4) begin
      e = m_board[(yo / 108) * 4 + (xo / 108)];
      return (e < 12) ? lut[e] : 12'h000;
    end
    return 12'hBAA;
  endfunction

  always @(posedge clk or negedge clrn) begin : model
    int x, y;
    if (!clrn) begin
      m_edges = 0;
      m_pos   = 0;
      m_hs    = 1'b1;
      m_vs    = 1'b1;
      m_rgb   = 12'h000;
      for (int i = 0; i < 16; i++) m_board[i] = i % 12;
    end else begin
      if (m_edges % 4 == 3) begin
        x = m_pos % 800;
        y = m_pos / 800;
        m_hs  = !(x >= 656 && x <= 751);
        m_vs  = !(y >= 490 && y <= 491);
        m_rgb = ref_colour(x, y);
        m_pos = (m_pos + 1) % (800 * 525);
      end
      if (rst) for (int i = 0; i < 16; i++) m_board[i] = 0;
      m_edges++;
    end
  end

  always @(negedge clk) begin
    check_eq("clkdiv", clkdiv, m_edges);
    check_eq("hs", 32'(hs), 32'(m_hs));
    check_eq("vs", 32'(vs), 32'(m_vs));
    check_eq("rgb", 32'({r, g, b}), 32'(m_rgb));
  end

  task automatic jump_to(input int line);
    @(negedge clk);
    force_v = 10'(line);
    force dut.u_timing.v_cnt_q = force_v;
    #1 release dut.u_timing.v_cnt_q;
    m_pos = line * 800 + (m_pos % 800);
  endtask

  task automatic run_seg(input int n, input bit pulse);
    int at;
    at = $urandom_range(0, n - 2);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = pulse && (k == at);
    end
    rst = 1'b0;
  endtask

  initial begin
    int lines_a [7] = '{5, 20, 27, 28, 70, 394, 459};
    int lines_b [4] = '{479, 489, 491, 524};
    #1 clrn = 1'b0;
    #99;
    @(negedge clk);
    clrn = 1'b1;
    run_seg(3300, 1'b0);

    foreach (lines_a[k]) begin
      jump_to(lines_a[k]);
      run_seg(3200, 1'b0);
    end

    // Cleared board: every tile should now be empty.
    run_seg(4, 1'b1);
    jump_to(127);
    run_seg(3200, 1'b0);
    jump_to(70);
    run_seg(3200, 1'b0);

    // Asynchronous reset away from any clock edge.
    run_seg($urandom_range(10, 2000), 1'b0);
    #2 clrn = 1'b0;
    #1;
    check_eq("async_clkdiv", clkdiv, 32'd0);
    check_eq("async_hs", 32'(hs), 32'd1);
    check_eq("async_vs", 32'(vs), 32'd1);
    check_eq("async_rgb", 32'({r, g, b}), 32'd0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    run_seg(3300, 1'b0);

    foreach (lines_b[k]) begin
      jump_to(lines_b[k]);
      run_seg(3200, 1'b0);
    end

    for (int k = 0; k < 3; k++) begin
      jump_to($urandom_range(0, 524));
      run_seg(3200, ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
